// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous memory port among NCH masters.
// Memory-side outputs are registered; read returns are tagged through a RD_LATENCY-deep pipe.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NCH        = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            req,
  input  logic [NCH-1:0]            we,
  input  logic [NCH*ADDR_WIDTH-1:0] addr,
  input  logic [NCH*WIDTH-1:0]      wdata,
  output logic [NCH-1:0]            gnt,
  output logic [NCH-1:0]            rvalid,
  output logic [WIDTH-1:0]          rdata,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]          mem_wdata,
  output logic                      mem_we,
  input  logic [WIDTH-1:0]          mem_rdata
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]                 gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]          mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]               mem_wdata_q, mem_wdata_d;
  logic                           mem_we_q, mem_we_d;
  logic [CW-1:0]                  last_q, last_d;
  logic [RD_LATENCY-1:0]          pv_q, pv_d;
  logic [RD_LATENCY-1:0][CW-1:0]  pc_q, pc_d;

  logic [NCH-1:0] eligible;
  logic           found;
  logic [CW-1:0]  win;
  int unsigned    cand;

  // Search upward from last+1, wrapping; a channel granted this cycle is excluded.
  always_comb begin
    eligible = req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= 32'(NCH)) cand = cand - 32'(NCH);
      if (!found && eligible[CW'(cand)]) begin
        found = 1'b1;
        win   = CW'(cand);
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d      = last_q;
    if (found) begin
      gnt_d[win]  = 1'b1;
      mem_we_d    = we[win];
      mem_addr_d  = addr[win*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_d = wdata[win*WIDTH +: WIDTH];
      last_d      = win;
    end
    // Stage 0 captures the access currently on the memory port; last_q names its channel.
    pv_d    = '0;
    pc_d    = '0;
    pv_d[0] = (|gnt_q) & ~mem_we_q;
    pc_d[0] = last_q;
    for (int unsigned s = 1; s < RD_LATENCY; s++) begin
      pv_d[s] = pv_q[s-1];
      pc_d[s] = pc_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      last_q      <= CW'(NCH-1);
      pv_q        <= '0;
      pc_q        <= '0;
    end else begin
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      last_q      <= last_d;
      pv_q        <= pv_d;
      pc_q        <= pc_d;
    end
  end

  always_comb begin
    rvalid = '0;
    if (pv_q[RD_LATENCY-1]) rvalid[pc_q[RD_LATENCY-1]] = 1'b1;
  end

  assign gnt       = gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rdata     = mem_rdata;

endmodule
